// File: rtl/z80_mcycle_memwr.sv
// Z80 memory-write M-cycle sequencer: T1-T2-(TW*)-T3 with registered bus outputs.
// Define Z80_MCYCLE_WAIT_EN to honour wait_n; otherwise wait_n is ignored and every cycle is T1-T2-T3.
module z80_mcycle_memwr (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        wait_n,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_data_oe,
    output logic        mreq_n,
    output logic        wr_n,
    output logic        busy,
    output logic        done,
    output logic [3:0]  tcycles
);

    localparam int unsigned TC_W = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TW   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;

    localparam logic [TC_W-1:0] TC_BASE = TC_W'(3);
    localparam logic [TC_W-1:0] TC_MAX  = TC_W'(15);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [TC_W-1:0] tcnt;
    logic [TC_W-1:0] tcnt_nxt;
    logic            accept;
    logic            wait_req;

`ifdef Z80_MCYCLE_WAIT_EN
    assign wait_req = ~wait_n;
`else
    logic unused_wait_n;
    assign unused_wait_n = wait_n;
    assign wait_req      = 1'b0;
`endif

    // Next-state and T-state count; tcnt starts at 3 and counts each wait state.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_T1;
                    tcnt_nxt  = TC_BASE;
                    accept    = 1'b1;
                end
            end
            S_T1: state_nxt = S_T2;
            S_T2, S_TW: begin
                if (wait_req) begin
                    state_nxt = S_TW;
                    tcnt_nxt  = (tcnt == TC_MAX) ? tcnt : tcnt + TC_W'(1);
                end else begin
                    state_nxt = S_T3;
                end
            end
            S_T3:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Bus strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr    <= 16'h0000;
            bus_data    <= 8'h00;
            bus_data_oe <= 1'b0;
            mreq_n      <= 1'b1;
            wr_n        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            tcycles     <= '0;
        end else begin
            if (accept) begin
                bus_addr <= addr;
                bus_data <= wdata;
            end
            bus_data_oe <= (state_nxt != S_IDLE);
            mreq_n      <= (state_nxt == S_IDLE);
            wr_n        <= !((state_nxt == S_T2) || (state_nxt == S_TW));
            busy        <= (state_nxt != S_IDLE);
            done        <= (state == S_T3);
            if (state == S_T3) begin
                tcycles <= tcnt;
            end
        end
    end

endmodule

// File: tb/tb_z80_mcycle_memwr.sv
// Scoreboard bench for z80_mcycle_memwr: driver pushes expected transactions, monitor checks each done.
module tb_z80_mcycle_memwr;

    localparam longint PERIOD = 10;
`ifdef Z80_MCYCLE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wait_n;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_data_oe;
    logic        mreq_n;
    logic        wr_n;
    logic        busy;
    logic        done;
    logic [3:0]  tcycles;

    z80_mcycle_memwr dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (addr),
        .wdata      (wdata),
        .wait_n     (wait_n),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_data_oe(bus_data_oe),
        .mreq_n     (mreq_n),
        .wr_n       (wr_n),
        .busy       (busy),
        .done       (done),
        .tcycles    (tcycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          n;
        longint      tdone;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   mreq_cnt = 0;
    int   wr_cnt   = 0;
    int   oe_cnt   = 0;

    task automatic check(input string nm, input longint unsigned got, input longint unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Wait states actually taken: only honoured when the wait feature is built in.
    function automatic int n_eff(input int n);
        return WAIT_EN ? n : 0;
    endfunction

    function automatic logic [3:0] exp_tc(input int ne);
        return (3 + ne > 15) ? 4'd15 : 4'(3 + ne);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_bus_addr"}, bus_addr, 16'h0000);
        check({tag, "_bus_data"}, bus_data, 8'h00);
        check({tag, "_oe"}, bus_data_oe, 0);
        check({tag, "_mreq_n"}, mreq_n, 1);
        check({tag, "_wr_n"}, wr_n, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tcycles"}, tcycles, 0);
    endtask

    // Monitor: counts strobe cycles, checks held bus values, pops on done.
    always @(negedge clk) begin
        if (reset) begin
            mreq_cnt = 0;
            wr_cnt   = 0;
            oe_cnt   = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_addr", bus_addr, mon_e.a);
                check("done_data", bus_data, mon_e.d);
                check("tcycles", tcycles, exp_tc(mon_e.n));
                check("mreq_low_cycles", mreq_cnt, 3 + mon_e.n);
                check("wr_low_cycles", wr_cnt, 1 + mon_e.n);
                check("oe_cycles", oe_cnt, 3 + mon_e.n);
                check("done_time", longint'($time), mon_e.tdone);
                check("done_mreq_n", mreq_n, 1);
                check("done_busy", busy, 0);
            end
            mreq_cnt = 0;
            wr_cnt   = 0;
            oe_cnt   = 0;
        end else begin
            if (!mreq_n) mreq_cnt++;
            if (!wr_n) wr_cnt++;
            if (bus_data_oe) oe_cnt++;
            if (busy && sb.size() > 0) begin
                check("hold_addr", bus_addr, sb[0].a);
                check("hold_data", bus_data, sb[0].d);
            end
        end
    end

    task automatic idle(input int k);
        start = 1'b0;
        repeat (k) begin
            @(negedge clk);
            start  = 1'b0;
            addr   = 16'($urandom);
            wdata  = 8'($urandom);
            wait_n = 1'($urandom);
        end
    endtask

    // One write cycle, entered at a negedge; returns on the done negedge (or after an abort reset).
    task automatic txn(input logic [15:0] a, input logic [7:0] d, input int n,
                       input bit poke, input int abort_t);
        exp_t   e;
        int     ne;
        longint base;
        ne     = n_eff(n);
        base   = (longint'($time) / PERIOD) * PERIOD;
        start  = 1'b1;
        addr   = a;
        wdata  = d;
        wait_n = 1'b1;
        e.a = a;
        e.d = d;
        e.n = ne;
        e.tdone = base + (4 + ne) * PERIOD;
        sb.push_back(e);
        for (int t = 1; t <= 4 + ne; t++) begin
            @(negedge clk);
            start  = 1'b0;
            addr   = 16'($urandom);
            wdata  = 8'($urandom);
            wait_n = (t >= 2 && t < 2 + n) ? 1'b0 : 1'b1;
            if (poke && t == 2) begin
                start = 1'b1;
                addr  = 16'hFFFF;
            end
            if (t == abort_t) begin
                #2 reset = 1'b1;
                #1 check_reset("abort");
                sb.delete();
                @(negedge clk);
                #2 reset = 1'b0;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        addr   = 16'h0;
        wdata  = 8'h0;
        wait_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset("init");
        #1 reset = 1'b0;
        @(negedge clk);

        txn(16'h1234, 8'h5A, 0, 1'b0, 0);
        idle(2);
        txn(16'h1234, 8'h5A, 2, 1'b0, 0);
        idle(1);
        txn(16'h1234, 8'h5A, 0, 1'b1, 0);
        txn(16'h00FF, 8'hA5, 0, 1'b0, 0);
        idle(1);
        txn(16'h1234, 8'h5A, 2, 1'b0, 3);
        txn(16'h1234, 8'h5A, 0, 1'b0, 0);
        idle(1);
        txn(16'hBEEF, 8'h11, 14, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
            txn(16'($urandom), 8'($urandom), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), 0);
        end

        idle(2);
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        check("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/z80_mcycle_memwr.md
Z80_MCYCLE_MEMWR -- requirements
Module: z80_mcycle_memwr

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is asynchronous and active-high. Ports: clk  in  1  clock, all state changes on its rising edge; reset  in  1  asynchronous active-high reset.
REQ-002 Ports (name  direction  width  meaning): start  in  1  single-cycle request for one memory-write M-cycle.
REQ-003 addr  in  16  write address, e.g. BC/DE for LD (BC/DE),A; captured on an accepted start.
REQ-004 wdata  in  8  write data, e.g. A; captured on an accepted start.
REQ-005 wait_n  in  1  Z80 WAIT, active-low, sampled on the rising edge that ends T2/TW.
REQ-006 bus_addr  out  16  registered address bus.
REQ-007 bus_data  out  8  registered data bus.
REQ-008 bus_data_oe  out  1  data bus drive enable.
REQ-009 mreq_n  out  1  memory request, active-low.
REQ-010 wr_n  out  1  write strobe, active-low.
REQ-011 busy  out  1  high while the M-cycle is in progress.
REQ-012 done  out  1  one-cycle pulse marking completion.
REQ-013 tcycles  out  4  T-states used by the last cycle; valid while done is high.

Function
REQ-014 The state machine SHALL have the states IDLE, T1, T2, TW and T3, and every clk cycle SHALL be exactly one T-state.
REQ-015 A start sampled high in IDLE SHALL be accepted: it captures addr/wdata into bus_addr/bus_data and moves the block to T1.
REQ-016 A start while busy is high SHALL be ignored and SHALL NOT be queued.
REQ-017 T1 SHALL be T2's only predecessor, and T1 SHALL always go to T2.
REQ-018 In T2, wait_n low SHALL go to TW; wait_n high SHALL go to T3.
REQ-019 In TW, wait_n low SHALL stay in TW; wait_n high SHALL go to T3. The number of wait states is unbounded.
REQ-020 T3 SHALL always go to IDLE.
REQ-021 mreq_n and bus_data_oe SHALL be asserted in T1, T2, TW and T3, and deasserted in IDLE.
REQ-022 wr_n SHALL be low in T2 and TW only, and high in T1, T3 and IDLE.
REQ-023 busy SHALL be high exactly when the state is not IDLE.
REQ-024 bus_addr and bus_data SHALL hold the captured values, unchanged, from T1 through the first IDLE cycle after T3.
REQ-025 done SHALL be high for exactly the one cycle following T3.
REQ-026 Latency: start accepted at edge k gives done high in the cycle after edge k+3+n, where n is the number of TW states.
REQ-027 tcycles SHALL equal 3+n, saturate at 15, and hold its value until the next done.
REQ-028 A start in the same cycle that done is high SHALL be accepted, since the state is IDLE, giving back-to-back cycles with one idle T-state between them.
REQ-029 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-030 Reset SHALL force, asynchronously: state IDLE, bus_addr 16'h0000, bus_data 8'h00, bus_data_oe 0, mreq_n 1, wr_n 1, busy 0, done 0, tcycles 0.
REQ-031 Reset asserted mid-cycle, in any of T1/T2/TW/T3, SHALL abort the cycle immediately with no done pulse.
REQ-032 After reset deasserts, the first rising edge SHALL accept start.

Configuration
REQ-033 Macro Z80_MCYCLE_WAIT_EN defined: wait_n SHALL be honoured as in REQ-018 and REQ-019.
REQ-034 Macro Z80_MCYCLE_WAIT_EN undefined: wait_n SHALL be ignored, TW SHALL be unreachable, every cycle SHALL be T1-T2-T3, and tcycles SHALL be constant 3.

Verification
REQ-035 start with addr=16'h1234, wdata=8'h5A, wait_n=1 -> mreq_n low for 3 cycles, wr_n low 1 cycle (T2), bus_addr=1234, bus_data=5A, done 3 cycles after the accept edge, tcycles=3.
REQ-036 With WAIT_EN, same stimulus with wait_n low for 2 edges from T2 -> 2 TW states, wr_n low 3 cycles, tcycles=5, done delayed by 2.
REQ-037 start pulsed again during T2 with addr=16'hFFFF -> ignored; bus_addr stays 1234; exactly one done.
REQ-038 start in the done cycle with addr=16'h00FF, wdata=8'hA5 -> new T1 immediately after; mreq_n high for exactly 1 cycle between the two cycles.
REQ-039 reset asserted during TW -> all outputs at reset values in the same cycle (asynchronous), no done; a following start behaves per REQ-035.
REQ-040 Without WAIT_EN, wait_n held low -> T1-T2-T3 still completes, tcycles=3.
